// File: rtl/lock_code_checker.sv
// lock_code_checker
// Holds the stored password and the current guess. A submit edge compares the
// two and drives unlock / wrong-guess / lockout indications, with a retry
// limit followed by a timed lockout.
// Optional feature: define LOCK_MASTER_CODE_EN to let MASTER_CODE open the
// lock from ARMED or LOCKOUT. Without the macro MASTER_CODE has no effect.
module lock_code_checker #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned OPEN_CYCLES    = 50_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
  parameter logic [3:0]  MASTER_CODE    = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] set_code,
  input  logic       set_en,
  input  logic       set_clr,
  input  logic [3:0] guess_code,
  input  logic       guess_en,
  input  logic       guess_clr,
  input  logic       submit,
  output logic       unlocked,
  output logic       wrong,
  output logic       locked_out,
  output logic [1:0] attempts_left,
  output logic [2:0] state_out
);

  localparam int unsigned TIMER_W = 26;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TRIES     = CNT_W'(MAX_TRIES);

`ifdef LOCK_MASTER_CODE_EN
  localparam bit MASTER_EN = 1'b1;
`else
  localparam bit MASTER_EN = 1'b0;
`endif

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CODE_W-1:0]    r_pw_reg;
  logic                 r_pw_valid;
  logic [CODE_W-1:0]    r_guess_reg;
  logic                 r_submit_q;
  logic [CNT_W-1:0]     r_fail_cnt;
  logic [CNT_W-1:0]     w_fail_next;
  logic [CNT_W-1:0]     w_fail_inc;
  logic [TIMER_W-1:0]   r_timer;

  logic                 w_sub_pulse;
  logic                 w_pw_writable;
  logic                 w_master_hit;
  logic                 w_match;
  logic                 w_open_done;
  logic                 w_lock_done;

  logic                 r_unlocked;
  logic                 r_wrong;
  logic                 r_locked_out;
  logic [CNT_W-1:0]     r_attempts_left;
  logic [STATE_W-1:0]   r_state_out;

  // Rising-edge detect so a held button yields one attempt
  assign w_sub_pulse   = submit & ~r_submit_q;
  assign w_pw_writable = (r_state == ST_IDLE) || (r_state == ST_OPEN);
  // Constant-folds to 0 when the master-code feature is compiled out
  assign w_master_hit  = MASTER_EN && (r_guess_reg == MASTER_CODE);
  assign w_match       = (r_guess_reg == r_pw_reg) || w_master_hit;
  assign w_open_done   = (r_timer == OPEN_LAST);
  assign w_lock_done   = (r_timer == LOCK_LAST);
  // Failure counter increment, saturating at the retry limit
  assign w_fail_inc    = (r_fail_cnt >= TRIES) ? TRIES : r_fail_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and failure-count logic
  always_comb begin
    w_state_next = r_state;
    w_fail_next  = r_fail_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!set_clr && r_pw_valid && !set_en) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_sub_pulse) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          w_state_next = ST_OPEN;
          w_fail_next  = '0;
        end else begin
          w_fail_next = w_fail_inc;
          if (w_fail_inc == TRIES) begin
            w_state_next = ST_LOCKOUT;
          end else begin
            w_state_next = ST_FAIL;
          end
        end
      end
      ST_OPEN: begin
        if (set_clr) begin
          w_state_next = ST_IDLE;
        end else if (w_open_done) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_FAIL: begin
        w_state_next = ST_ARMED;
      end
      ST_LOCKOUT: begin
        if (w_sub_pulse && w_master_hit) begin
          w_state_next = ST_CHECK;
          w_fail_next  = '0;
        end else if (w_lock_done) begin
          w_state_next = ST_ARMED;
          w_fail_next  = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_fail_next  = '0;
      end
    endcase
  end

  // Failure counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_cnt <= '0;
    end else begin
      r_fail_cnt <= w_fail_next;
    end
  end

  // Dwell timer: cleared on every state change, counts only in OPEN/LOCKOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_state_next != r_state) begin
      r_timer <= '0;
    end else if ((r_state == ST_OPEN) || (r_state == ST_LOCKOUT)) begin
      r_timer <= r_timer + TIMER_W'(1);
    end else begin
      r_timer <= '0;
    end
  end

  // Password register: writable only in IDLE and OPEN, clear beats load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pw_reg   <= '0;
      r_pw_valid <= 1'b0;
    end else if (w_pw_writable) begin
      if (set_clr) begin
        r_pw_reg   <= '0;
        r_pw_valid <= 1'b0;
      end else if (set_en) begin
        r_pw_reg   <= set_code;
        r_pw_valid <= 1'b1;
      end
    end
  end

  // Guess register: loads in any state, clear beats load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_guess_reg <= '0;
    end else if (guess_clr) begin
      r_guess_reg <= '0;
    end else if (guess_en) begin
      r_guess_reg <= guess_code;
    end
  end

  // Submit history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_submit_q <= 1'b0;
    end else begin
      r_submit_q <= submit;
    end
  end

  // Registered outputs, decoded from the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_unlocked      <= 1'b0;
      r_wrong         <= 1'b0;
      r_locked_out    <= 1'b0;
      r_attempts_left <= TRIES;
      r_state_out     <= STATE_W'(ST_IDLE);
    end else begin
      r_unlocked      <= (w_state_next == ST_OPEN);
      r_wrong         <= (w_state_next == ST_FAIL);
      r_locked_out    <= (w_state_next == ST_LOCKOUT);
      r_attempts_left <= TRIES - w_fail_next;
      r_state_out     <= STATE_W'(w_state_next);
    end
  end

  assign unlocked      = r_unlocked;
  assign wrong         = r_wrong;
  assign locked_out    = r_locked_out;
  assign attempts_left = r_attempts_left;
  assign state_out     = r_state_out;

endmodule

// File: tb/tb_lock_code_checker.sv
// Testbench for lock_code_checker: directed scenarios with literal expectations
// plus randomized stimulus, all checked every cycle against a behavioural model.
// Honours LOCK_MASTER_CODE_EN the same way the design does.
module tb_lock_code_checker;

  localparam int MAX_TRIES      = 3;
  localparam int OPEN_CYCLES    = 4;
  localparam int LOCKOUT_CYCLES = 8;
  localparam logic [3:0] MASTER_CODE = 4'hF;

`ifdef LOCK_MASTER_CODE_EN
  localparam bit MASTER_EN = 1'b1;
`else
  localparam bit MASTER_EN = 1'b0;
`endif

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic [3:0] set_code   = 4'h0;
  logic       set_en     = 1'b0;
  logic       set_clr    = 1'b0;
  logic [3:0] guess_code = 4'h0;
  logic       guess_en   = 1'b0;
  logic       guess_clr  = 1'b0;
  logic       submit     = 1'b0;
  logic       unlocked;
  logic       wrong;
  logic       locked_out;
  logic [1:0] attempts_left;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  lock_code_checker #(
    .MAX_TRIES      (MAX_TRIES),
    .OPEN_CYCLES    (OPEN_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .MASTER_CODE    (MASTER_CODE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .set_code      (set_code),
    .set_en        (set_en),
    .set_clr       (set_clr),
    .guess_code    (guess_code),
    .guess_en      (guess_en),
    .guess_clr     (guess_clr),
    .submit        (submit),
    .unlocked      (unlocked),
    .wrong         (wrong),
    .locked_out    (locked_out),
    .attempts_left (attempts_left),
    .state_out     (state_out)
  );

  // Behavioural model: mode number plus a countdown of cycles left in the mode
  typedef struct {
    int         st;
    int         fails;
    int         left;
    logic [3:0] pw;
    logic [3:0] guess;
    bit         pwv;
    bit         subq;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t c, input bit r, input bit s_en, input bit s_clr,
                                input logic [3:0] s_code, input bit g_en, input bit g_clr,
                                input logic [3:0] g_code, input bit sub);
    mdl_t n;
    bit press;
    bit master_ok;
    n = c;
    if (r) begin
      n = '{0, 0, 0, 4'h0, 4'h0, 1'b0, 1'b0};
      return n;
    end
    press     = sub && !c.subq;
    master_ok = MASTER_EN && (c.guess == MASTER_CODE);
    case (c.st)
      0: if (!s_clr && c.pwv && !s_en) n.st = 1;
      1: if (press) n.st = 2;
      2: begin
        if (c.guess == c.pw || master_ok) begin
          n.st = 3; n.fails = 0; n.left = OPEN_CYCLES;
        end else begin
          n.fails = c.fails + 1;
          if (n.fails >= MAX_TRIES) begin
            n.fails = MAX_TRIES; n.st = 5; n.left = LOCKOUT_CYCLES;
          end else begin
            n.st = 4;
          end
        end
      end
      3: begin
        if (s_clr) n.st = 0;
        else if (c.left == 1) n.st = 1;
        else n.left = c.left - 1;
      end
      4: n.st = 1;
      5: begin
        if (press && master_ok) begin
          n.st = 2; n.fails = 0;
        end else if (c.left == 1) begin
          n.st = 1; n.fails = 0;
        end else begin
          n.left = c.left - 1;
        end
      end
      default: n.st = 0;
    endcase
    if (c.st == 0 || c.st == 3) begin
      if (s_clr) begin
        n.pw = 4'h0; n.pwv = 1'b0;
      end else if (s_en) begin
        n.pw = s_code; n.pwv = 1'b1;
      end
    end
    if (g_clr) n.guess = 4'h0;
    else if (g_en) n.guess = g_code;
    n.subq = sub;
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m, rst, set_en, set_clr, set_code, guess_en, guess_clr, guess_code, submit);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_state",    int'(state_out),     m.st);
      check("mdl_unlocked", int'(unlocked),      int'(m.st == 3));
      check("mdl_wrong",    int'(wrong),         int'(m.st == 4));
      check("mdl_locked",   int'(locked_out),    int'(m.st == 5));
      check("mdl_attempts", int'(attempts_left), MAX_TRIES - m.fails);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Guess load and submit press in the same cycle
  task automatic press(input logic [3:0] code);
    guess_code = code;
    guess_en   = 1'b1;
    submit     = 1'b1;
    cyc();
    guess_en   = 1'b0;
    submit     = 1'b0;
  endtask

  task automatic wait_state(input int exp, input int max_cyc, input string name);
    int n;
    n = 0;
    while (int'(state_out) != exp && n < max_cyc) begin
      cyc();
      n++;
    end
    check(name, int'(state_out), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wrong;

    // Reset
    rst = 1'b1;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    check("rst_state",    int'(state_out), 0);
    check("rst_attempts", int'(attempts_left), 3);
    check("rst_unlocked", int'(unlocked), 0);
    check("rst_wrong",    int'(wrong), 0);
    check("rst_locked",   int'(locked_out), 0);

    // Set password A and unlock
    set_code = 4'hA; set_en = 1'b1; cyc(); set_en = 1'b0; cyc();
    check("armed_after_set", int'(state_out), 1);
    press(4'hA);
    check("check_after_press", int'(state_out), 2);
    cyc();
    check("unlock_2cyc", int'(unlocked), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("unlock_hold", int'(unlocked), 1);
    end
    cyc();
    check("open_expire_state", int'(state_out), 1);
    check("open_expire_unl", int'(unlocked), 0);
    check("open_expire_att", int'(attempts_left), 3);

    // Retry and lockout
    for (int k = 0; k < 2; k++) begin
      press(4'h3);
      cyc();
      check("wrong_pulse", int'(wrong), 1);
      check("attempts_dec", int'(attempts_left), 2 - k);
      cyc();
      check("wrong_one_cycle", int'(wrong), 0);
      check("fail_to_armed", int'(state_out), 1);
    end
    press(4'h3);
    cyc();
    check("lockout_enter", int'(locked_out), 1);
    check("lockout_att", int'(attempts_left), 0);
    for (int i = 0; i < 7; i++) begin
      guess_code = 4'hA;
      guess_en   = (i == 1);
      submit     = (i == 2);
      cyc();
      check("lockout_hold", int'(state_out), 5);
    end
    guess_en = 1'b0; submit = 1'b0;
    cyc();
    check("lockout_exit", int'(state_out), 1);
    check("lockout_exit_att", int'(attempts_left), 3);

    // Held submit gives one attempt
    guess_code = 4'h3; guess_en = 1'b1; cyc(); guess_en = 1'b0;
    n_wrong = 0;
    submit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (wrong) n_wrong++;
    end
    submit = 1'b0;
    check("held_one_wrong", n_wrong, 1);
    check("held_attempts", int'(attempts_left), 2);
    cyc();

    // Password protected outside IDLE/OPEN
    set_clr = 1'b1; set_en = 1'b1; set_code = 4'h5; cyc(); set_clr = 1'b0; set_en = 1'b0;
    check("armed_ignores_set", int'(state_out), 1);
    press(4'hA); cyc();
    check("old_pw_unlocks", int'(unlocked), 1);
    check("unlock_clears_fail", int'(attempts_left), 3);
    set_code = 4'h5; set_en = 1'b1; cyc(); set_en = 1'b0;
    wait_state(1, 10, "reload_open_expire");
    press(4'h5); cyc();
    check("new_pw_unlocks", int'(unlocked), 1);
    wait_state(1, 10, "open_expire2");
    press(4'hA); cyc();
    check("old_pw_fails", int'(wrong), 1);
    cyc();

    // Clear beats load on the guess register (password set to 0 to observe it)
    press(4'h5); cyc();
    check("unlock_for_pw0", int'(unlocked), 1);
    set_code = 4'h0; set_en = 1'b1; cyc(); set_en = 1'b0;
    wait_state(1, 10, "open_expire3");
    guess_code = 4'h7; guess_en = 1'b1; guess_clr = 1'b1; cyc();
    guess_en = 1'b0; guess_clr = 1'b0;
    submit = 1'b1; cyc(); submit = 1'b0; cyc();
    check("guess_clr_prio", int'(unlocked), 1);

    // Reset in the middle of OPEN
    cyc();
    check("open_cycle2", int'(unlocked), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("midopen_rst_state", int'(state_out), 0);
    check("midopen_rst_unl",   int'(unlocked), 0);
    check("midopen_rst_att",   int'(attempts_left), 3);
    press(4'h0); cyc();
    check("idle_ignores_submit", int'(state_out), 0);

    // Master code during lockout
    set_code = 4'hA; set_en = 1'b1; cyc(); set_en = 1'b0; cyc();
    check("rearm", int'(state_out), 1);
    for (int k = 0; k < 3; k++) begin
      press(4'h3); cyc();
      if (k < 2) cyc();
    end
    check("lock2_enter", int'(locked_out), 1);
    guess_code = 4'hF; guess_en = 1'b1; cyc(); guess_en = 1'b0;
    submit = 1'b1; cyc(); submit = 1'b0;
`ifdef LOCK_MASTER_CODE_EN
    check("master_to_check", int'(state_out), 2);
    cyc();
    check("master_unlock", int'(unlocked), 1);
    check("master_attempts", int'(attempts_left), 3);
`else
    check("no_master_locked", int'(locked_out), 1);
    cyc();
    check("no_master_locked2", int'(locked_out), 1);
    wait_state(1, 12, "lock2_expire");
    check("lock2_exit_att", int'(attempts_left), 3);
`endif

    // Randomized stimulus, checked by the model every cycle
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      set_en     = ($urandom_range(0, 9) == 0);
      set_clr    = ($urandom_range(0, 29) == 0);
      set_code   = 4'($urandom_range(0, 3));
      guess_en   = ($urandom_range(0, 2) == 0);
      guess_clr  = ($urandom_range(0, 19) == 0);
      guess_code = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) submit = ~submit;
      cyc();
    end
    rst = 1'b0; set_en = 1'b0; set_clr = 1'b0; guess_en = 1'b0; guess_clr = 1'b0; submit = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_code_checker.md
# lock_code_checker

Consumer side of the code-entry selector: takes the routed set-code and guess-code nibbles with their enables and clears, and holds the stored password and the current guess. On a submit press it compares the two and drives unlock, wrong-guess and lockout indications to the display and LED logic. A parameterised retry limit with a timed lockout prevents brute-force entry.

## Interface
- `MAX_TRIES`, default 3: failed submits before lockout; legal range 1..3.
- `OPEN_CYCLES`, default 50_000_000: cycles `unlocked` is held after a correct guess.
- `LOCKOUT_CYCLES`, default 50_000_000: cycles spent in lockout.
- `MASTER_CODE`, default 4'hF: override code; used only when `LOCK_MASTER_CODE_EN` is defined.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `set_code` in 4: password nibble from the selector's set path.
- `set_en` in 1: password path active.
- `set_clr` in 1: clear stored password.
- `guess_code` in 4: guess nibble from the selector's guess path.
- `guess_en` in 1: guess path active.
- `guess_clr` in 1: clear guess register.
- `submit` in 1: level from the debounced submit button.
- `unlocked` out 1: high in OPEN.
- `wrong` out 1: one-cycle pulse on a failed guess.
- `locked_out` out 1: high in LOCKOUT.
- `attempts_left` out 2: remaining tries before lockout.
- `state_out` out 3: state encoding for the display.

## Operation
- States and `state_out` encoding: IDLE=0, ARMED=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5.
- Password register `pw_reg[3:0]` and flag `pw_valid`:
  - Writable only in IDLE and OPEN.
  - When `set_en`=1, `pw_reg` loads `set_code` and `pw_valid` is set.
  - When `set_clr`=1, `pw_reg` and `pw_valid` are cleared and the state goes to IDLE. `set_clr` has priority over `set_en`.
  - In any other state, `set_en` and `set_clr` are ignored.
- Guess register `guess_reg[3:0]`:
  - Loads `guess_code` when `guess_en`=1, in any state.
  - `guess_clr` zeroes it and has priority over `guess_en`.
- Submit edge detect: `submit_q` is registered; `sub_pulse = submit & ~submit_q`. Holding `submit` high produces exactly one attempt.
- State transitions:
  - IDLE → ARMED when `pw_valid`=1 and `set_en`=0.
  - ARMED → CHECK on `sub_pulse`.
  - CHECK compares `guess_reg` with `pw_reg`:
    - Equal → OPEN; `fail_cnt` is cleared.
    - Not equal → `fail_cnt` is incremented. If the new count equals `MAX_TRIES`, go to LOCKOUT; otherwise go to FAIL.
  - FAIL → ARMED after exactly 1 cycle.
  - OPEN → ARMED when the timer reaches `OPEN_CYCLES-1`.
  - OPEN with `set_en`=0 and `pw_valid` cleared by `set_clr` → IDLE.
  - LOCKOUT → ARMED when the timer reaches `LOCKOUT_CYCLES-1`; `fail_cnt` is cleared on exit.
- `sub_pulse` is ignored in every state except ARMED, except as noted under Configuration.
- Timer: 26-bit up-counter. It resets to 0 on every state entry and counts only in OPEN and LOCKOUT.
- `attempts_left` = `MAX_TRIES - fail_cnt`. `fail_cnt` is 2 bits and saturates at `MAX_TRIES`.
- All outputs are registered, or decoded from registered state only.

## Timing
- Reset values: state=IDLE, `pw_reg`=0, `pw_valid`=0, `guess_reg`=0, `fail_cnt`=0, timer=0, `submit_q`=0.
- Output values at reset: `unlocked`=0, `wrong`=0, `locked_out`=0, `attempts_left`=`MAX_TRIES`, `state_out`=0.
- Submit latency:
  - `submit` first sampled high at edge E0 → state=CHECK after E0.
  - At E1 → OPEN, FAIL or LOCKOUT.
  - `unlocked`, `wrong` or `locked_out` is visible after E1: 2 cycles from the press.
- `guess_en` asserted in the same cycle as the submit press: `guess_reg` updates at E0, so the compare at E1 uses the new guess.
- `unlocked` is high for exactly `OPEN_CYCLES` cycles. `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles. `wrong` is high for exactly 1 cycle.
- `rst` in any state, including mid-OPEN or mid-LOCKOUT, restores all reset values at the next edge. The stored password is lost.

## Configuration
- `LOCK_MASTER_CODE_EN` defined:
  - In ARMED and in LOCKOUT, a `sub_pulse` while `guess_reg == MASTER_CODE` goes to CHECK.
  - CHECK treats `MASTER_CODE` as a match: → OPEN, `fail_cnt` cleared, lockout timer abandoned.
  - A non-master guess during LOCKOUT is still ignored.
- `LOCK_MASTER_CODE_EN` undefined:
  - `MASTER_CODE` is unused and generates no logic.
  - LOCKOUT can be left only by timer expiry or `rst`.

## Test plan
Bench parameters: `MAX_TRIES`=3, `OPEN_CYCLES`=4, `LOCKOUT_CYCLES`=8, `MASTER_CODE`=4'hF.
- Set and unlock: `set_en`=1 with `set_code`=4'hA, then `set_en`=0 → ARMED. `guess_code`=4'hA with `guess_en` and `submit` asserted together → `unlocked`=1 two cycles after the press, held 4 cycles, then state=ARMED, `attempts_left`=3.
- Retry and lockout: three submits of 4'h3 against password 4'hA:
  - `wrong` pulses twice; `attempts_left` goes 2 then 1.
  - The third submit gives `locked_out`=1 for 8 cycles, then ARMED with `attempts_left`=3.
  - A submit of 4'hA during LOCKOUT causes no state change.
- Held submit: `submit` held high for 20 cycles with a wrong guess → exactly one `wrong` pulse; `attempts_left`=2.
- Protected password:
  - In ARMED, `set_clr`=1 and `set_en` with `set_code`=4'h5 are both ignored; 4'hA still unlocks.
  - In OPEN, `set_code`=4'h5 with `set_en` reloads the password; afterwards 4'h5 unlocks and 4'hA fails.
- Clear priority and reset:
  - `guess_clr` and `guess_en` in the same cycle → `guess_reg`=0.
  - `rst` at cycle 2 of OPEN → all outputs at reset values and state=IDLE; a submit then has no effect.
- Master code, with `LOCK_MASTER_CODE_EN` defined: in LOCKOUT, a submit of 4'hF → `unlocked`=1 two cycles later and `attempts_left`=3. Without the macro, the same stimulus leaves `locked_out`=1 until the timer expires.
